fetch_decode: RTL and testbench

Front-end stage of the RISC-V CPU: fetches 32-bit RV32I instruction words from instruction memory, buffers them in a small instruction queue and issues one decoded instruction per cycle to the reservation-station/rename stage. That stage receives the decoded fields (`opcode`, `rd`, `fun3`, `rs1`, `rs2`, `fun7`, `imm`, `opc`). It returns `is_busy` to stall issue and `get_npc`/`npc` to redirect fetch. An all-zero issue (opcode 0) is a bubble and the downstream stage ignores it.

---
 rtl/fetch_decode.sv | 187 ++++++++++++++++++
 tb/tb_fetch_decode.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// RV32I front end: single-outstanding fetch FSM feeding a small instruction queue,
// with one registered decode/issue per cycle and fetch redirect on get_npc.
module fetch_decode #(
    parameter int unsigned IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        is_busy,
    input  logic        get_npc,
    input  logic [31:0] npc,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  fun3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  fun7,
    output logic [31:0] imm,
    output logic [31:0] opc,
    output logic        illegal
);

    localparam int unsigned PtrW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpOp     = 7'b0110011;

    typedef enum logic {StIdle, StWait} fetch_state_e;

    fetch_state_e    state_q;
    logic [31:0]     pc_q;
    logic            discard_q;
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [CntW-1:0] count_q;

    logic [31:0] q_pc   [IQ_DEPTH];
    logic [31:0] q_word [IQ_DEPTH];

    logic        do_pop;
    logic        do_push;
    logic        queue_full;
    logic [31:0] npc_aligned;
    logic [31:0] head_word;
    logic [31:0] head_pc;
    logic [31:0] imm_dec;
    logic        legal;

    assign npc_aligned = npc & ~32'h3;
    assign head_word   = q_word[head_q];
    assign head_pc     = q_pc[head_q];
    assign queue_full  = (count_q == CntW'(IQ_DEPTH));
    assign do_pop      = !get_npc && !is_busy && (count_q != '0);
    // A response that arrives together with a redirect belongs to the old path.
    assign do_push     = (state_q == StWait) && imem_valid && !discard_q && !get_npc;

    always_comb begin
        imm_dec = '0;
        legal   = 1'b1;
        case (head_word[6:0])
            OpLoad, OpOpImm, OpJalr:
                imm_dec = {{20{head_word[31]}}, head_word[31:20]};
            OpStore:
                imm_dec = {{20{head_word[31]}}, head_word[31:25], head_word[11:7]};
            OpBranch:
                imm_dec = {{19{head_word[31]}}, head_word[31], head_word[7],
                           head_word[30:25], head_word[11:8], 1'b0};
            OpLui, OpAuipc:
                imm_dec = {head_word[31:12], 12'b0};
            OpJal:
                imm_dec = {{11{head_word[31]}}, head_word[31], head_word[19:12],
                           head_word[20], head_word[30:21], 1'b0};
            OpOp:
                imm_dec = '0;
            default:
                legal = 1'b0;
        endcase
    end

    // Queue storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_word[tail_q] <= imem_rdata;
            q_pc[tail_q]   <= pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            opcode    <= '0;
            rd        <= '0;
            fun3      <= '0;
            rs1       <= '0;
            rs2       <= '0;
            fun7      <= '0;
            imm       <= '0;
            opc       <= '0;
            illegal   <= 1'b0;
        end else begin
            if (do_pop && legal) begin
                opcode  <= head_word[6:0];
                rd      <= head_word[11:7];
                fun3    <= head_word[14:12];
                rs1     <= head_word[19:15];
                rs2     <= head_word[24:20];
                fun7    <= head_word[31:25];
                imm     <= imm_dec;
                opc     <= head_pc;
                illegal <= 1'b0;
            end else begin
                opcode  <= '0;
                rd      <= '0;
                fun3    <= '0;
                rs1     <= '0;
                rs2     <= '0;
                fun7    <= '0;
                imm     <= '0;
                opc     <= '0;
                illegal <= do_pop;
            end

            if (get_npc) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (do_pop) begin
                    head_q <= head_q + 1'b1;
                end
                if (do_push) begin
                    tail_q <= tail_q + 1'b1;
                end
                count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
            end

            unique case (state_q)
                StIdle: begin
                    if (get_npc) begin
                        pc_q <= npc_aligned;
                    end else if (!queue_full) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc_q;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (imem_valid) begin
                        imem_req  <= 1'b0;
                        discard_q <= 1'b0;
                        state_q   <= StIdle;
                        if (get_npc) begin
                            pc_q <= npc_aligned;
                        end else if (!discard_q) begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end else if (get_npc) begin
                        // Request stays up until memory answers; the answer is then dropped.
                        discard_q <= 1'b1;
                        pc_q      <= npc_aligned;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: memory responder, transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_decode;

    localparam int unsigned Depth   = 4;
    localparam logic [31:0] ResetPc = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        is_busy;
    logic        get_npc;
    logic [31:0] npc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  fun3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  fun7;
    logic [31:0] imm;
    logic [31:0] opc;
    logic        illegal;

    fetch_decode #(.IQ_DEPTH(Depth), .RESET_PC(ResetPc)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .is_busy(is_busy), .get_npc(get_npc), .npc(npc),
        .opcode(opcode), .rd(rd), .fun3(fun3), .rs1(rs1), .rs2(rs2), .fun7(fun7),
        .imm(imm), .opc(opc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [96:0] dut_out;
    assign dut_out = {opcode, rd, fun3, rs1, rs2, fun7, imm, opc, illegal};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Program image: a few fixed words, a mix of formats elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [6:0]  op;
        case (a)
            32'h100: return 32'hFE010113;
            32'h104: return 32'hFE000EE3;
            32'h108: return 32'hABCDE0B7;
            32'h10C: return 32'h0000007F;
            32'h110: return 32'h00A30233;
            default: begin
                h = a * 32'h9E3779B9;
                case (a[4:2])
                    3'd0: op = 7'b0010011;
                    3'd1: op = 7'b0000011;
                    3'd2: op = 7'b0100011;
                    3'd3: op = 7'b1100011;
                    3'd4: op = 7'b0110111;
                    3'd5: op = 7'b0010111;
                    3'd6: op = 7'b1101111;
                    default: op = 7'b0110011;
                endcase
                if (a[9:2] == 8'h55) op = 7'b0001111;
                return {h[31:7], op};
            end
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    // Expected issue vector for one queued word, from the format rules.
    function automatic logic [96:0] expect_issue(input ent_t e);
        logic [31:0]        w;
        logic signed [31:0] sw;
        logic [31:0]        t;
        logic [31:0]        iv;
        bit                 ok;
        w  = e.w;
        sw = e.w;
        iv = '0;
        ok = 1'b1;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: iv = sw >>> 20;
            7'b0100011: begin
                t  = sw >>> 25;
                iv = (t << 5) | 32'(w[11:7]);
            end
            7'b1100011: iv = (w[31] ? 32'hFFFFF000 : 32'h0) + (32'(w[7]) << 11)
                           + (32'(w[30:25]) << 5) + (32'(w[11:8]) << 1);
            7'b0110111, 7'b0010111: iv = w & 32'hFFFFF000;
            7'b1101111: iv = (w[31] ? 32'hFFF00000 : 32'h0) + (32'(w[19:12]) << 12)
                           + (32'(w[20]) << 11) + (32'(w[30:21]) << 1);
            7'b0110011: iv = 32'h0;
            default: ok = 1'b0;
        endcase
        if (!ok) return 97'd1;
        return {w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[31:25], iv, e.pc, 1'b0};
    endfunction

    // Reference model: program-order queue plus one outstanding fetch.
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_fetching;
    bit          m_drop;
    int          m_n;
    ent_t        m_ent;
    logic [96:0] e_out;
    logic        e_req;
    logic [31:0] e_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc       = ResetPc;
            m_fetching = 1'b0;
            m_drop     = 1'b0;
            e_out      = '0;
            e_req      = 1'b0;
            e_addr     = '0;
        end else begin
            m_n = mq.size();
            if (!get_npc && !is_busy && m_n > 0) begin
                m_ent = mq.pop_front();
                e_out = expect_issue(m_ent);
            end else begin
                e_out = '0;
            end
            if (get_npc) begin
                mq.delete();
                m_pc = npc & ~32'h3;
                if (m_fetching) begin
                    if (imem_valid) begin
                        m_fetching = 1'b0;
                        m_drop     = 1'b0;
                        e_req      = 1'b0;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
            end else if (m_fetching) begin
                if (imem_valid) begin
                    if (!m_drop) begin
                        m_ent.pc = m_pc;
                        m_ent.w  = imem_rdata;
                        mq.push_back(m_ent);
                        m_pc = m_pc + 32'd4;
                    end
                    m_drop     = 1'b0;
                    m_fetching = 1'b0;
                    e_req      = 1'b0;
                end
            end else if (m_n < Depth) begin
                m_fetching = 1'b1;
                e_req      = 1'b1;
                e_addr     = m_pc;
            end
        end
    end

    // Memory responder: answers each request after 'lat' extra cycles.
    int lat  = 0;
    int wcnt = 0;
    initial begin
        imem_valid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !imem_req) begin
                wcnt       = 0;
                imem_valid = 1'b0;
            end else if (wcnt >= lat) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wcnt       = 0;
            end else begin
                wcnt++;
                imem_valid = 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  fun3;
        logic [4:0]  rs1;
        logic [31:0] imm;
        logic [31:0] opc;
    } iss_t;

    iss_t        iss_log[$];
    logic [31:0] req_log[$];
    int          ill_cnt  = 0;
    logic        prev_req = 1'b0;
    iss_t        cur_iss;

    // Per-cycle comparison against the model, plus event logs for the directed checks.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                n_checks++;
                if (dut_out !== e_out || imem_req !== e_req || (e_req && imem_addr !== e_addr)) begin
                    n_fail++;
                    $display("FAIL model_cycle t=%0t: got out=%h req=%b addr=%h, expected out=%h req=%b addr=%h",
                             $time, dut_out, imem_req, imem_addr, e_out, e_req, e_addr);
                end
                if (imem_req && !prev_req) req_log.push_back(imem_addr);
                if (opcode != 7'd0) begin
                    cur_iss.opcode = opcode;
                    cur_iss.rd     = rd;
                    cur_iss.fun3   = fun3;
                    cur_iss.rs1    = rs1;
                    cur_iss.imm    = imm;
                    cur_iss.opc    = opc;
                    iss_log.push_back(cur_iss);
                end
                if (illegal) ill_cnt++;
                prev_req = imem_req;
            end else begin
                prev_req = 1'b0;
            end
        end
    end

    function automatic iss_t iss_at(input int i);
        if (i < iss_log.size()) return iss_log[i];
        return '1;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEADBEEF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iss_t e;
        rst_n   = 1'b0;
        is_busy = 1'b0;
        get_npc = 1'b0;
        npc     = '0;
        lat     = 0;
        repeat (3) @(negedge clk);
        check("reset_req", 128'(imem_req), 128'd0);
        check("reset_addr", 128'(imem_addr), 128'd0);
        check("reset_outputs", 128'(dut_out), 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_req", 128'(imem_req), 128'd1);
        check("first_addr", 128'(imem_addr), 128'h100);

        // Zero-wait fetch of the fixed program.
        repeat (30) @(negedge clk);
        check("req_addr0", 128'(req_at(0)), 128'h100);
        check("req_addr1", 128'(req_at(1)), 128'h104);
        check("req_addr2", 128'(req_at(2)), 128'h108);
        e = iss_at(0);
        check("addi_opc", 128'(e.opc), 128'h100);
        check("addi_opcode", 128'(e.opcode), 128'h13);
        check("addi_rd", 128'(e.rd), 128'd2);
        check("addi_rs1", 128'(e.rs1), 128'd2);
        check("addi_fun3", 128'(e.fun3), 128'd0);
        check("addi_imm", 128'(e.imm), 128'hFFFFFFE0);
        e = iss_at(1);
        check("beq_opc", 128'(e.opc), 128'h104);
        check("beq_imm", 128'(e.imm), 128'hFFFFFFFC);
        e = iss_at(2);
        check("lui_opc", 128'(e.opc), 128'h108);
        check("lui_imm", 128'(e.imm), 128'hABCDE000);
        e = iss_at(3);
        check("after_illegal_opc", 128'(e.opc), 128'h110);
        check("illegal_pulses", 128'(ill_cnt), 128'd1);

        // Stall issue long enough for the queue to fill.
        lat     = 3;
        is_busy = 1'b1;
        get_npc = 1'b1;
        npc     = 32'h300;
        @(negedge clk);
        get_npc = 1'b0;
        repeat (40) @(negedge clk);
        check("full_req_low", 128'(imem_req), 128'd0);
        is_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_opc", 128'(opc), 128'(32'h300 + 32'(4 * i)));
        end
        check("resume_req", 128'(imem_req), 128'd1);
        check("resume_addr", 128'(imem_addr), 128'h310);

        // Redirect while a request is outstanding.
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
        check("wait_state_req", 128'(imem_req), 128'd1);
        get_npc = 1'b1;
        npc     = 32'h201;
        @(posedge clk);
        #1;
        iss_log.delete();
        req_log.delete();
        check("redirect_bubble", 128'(opcode), 128'd0);
        @(negedge clk);
        get_npc = 1'b0;
        repeat (20) @(negedge clk);
        check("redirect_req_addr", 128'(req_at(0)), 128'h200);
        e = iss_at(0);
        check("redirect_first_opc", 128'(e.opc), 128'h200);

        // Mixed stalls, redirects, latencies and one reset mid-run.
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) lat = int'($urandom_range(0, 2));
            is_busy = ($urandom_range(0, 3) == 0);
            get_npc = ($urandom_range(0, 15) == 0);
            npc     = $urandom_range(0, 1023);
            if (c == 200) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("midrun_reset_req", 128'(imem_req), 128'd0);
                rst_n = 1'b1;
            end
            @(negedge clk);
        end
        is_busy = 1'b0;
        get_npc = 1'b0;
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
